// File: rtl/bw_frf_pkg.sv
// Shared constants and state encoding for the two-port FFU register file.
package bw_frf_pkg;

  localparam int unsigned FRF_HALF_W = 39;
  localparam int unsigned FRF_ADDR_W = 7;

  typedef enum logic {
    FRF_CLEAR = 1'b0,
    FRF_READY = 1'b1
  } frf_state_e;

endpackage

// File: rtl/bw_r_frf_2p_if.sv
// Request/response bundle between the FFU control (master) and the register file (slave).
interface bw_r_frf_2p_if
  import bw_frf_pkg::*;
#(
  parameter int unsigned HALF_W = FRF_HALF_W,
  parameter int unsigned ADDR_W = FRF_ADDR_W
);

  logic [1:0]          wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [2*HALF_W-1:0] wr_data;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [2*HALF_W-1:0] rd_data;
  logic                init_busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, init_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, init_busy
  );

endinterface

// File: rtl/bw_r_frf_bank.sv
// One half of the register file: synchronous write port, combinational read port.
module bw_r_frf_bank #(
  parameter int unsigned WIDTH  = 39,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; the clear sequencer in the top zeroes it entry by entry.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bw_r_frf_2p.sv
// Two-port FFU register file: flopped requests, per-half writes with read bypass,
// registered read data and a post-reset clear sequencer.
module bw_r_frf_2p
  import bw_frf_pkg::*;
#(
  parameter int unsigned HALF_W = FRF_HALF_W,
  parameter int unsigned ADDR_W = FRF_ADDR_W
) (
  input logic          rclk,
  input logic          reset,
  bw_r_frf_2p_if.slave frf
);

  localparam int unsigned W = 2 * HALF_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  logic [1:0]        wr_en_d1;
  logic [ADDR_W-1:0] wr_addr_d1;
  logic [W-1:0]      wr_data_d1;
  logic              rd_en_d1;
  logic [ADDR_W-1:0] rd_addr_d1;

  frf_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              busy;

  logic [1:0]        bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [W-1:0]      bank_wdata;
  logic [W-1:0]      bank_rdata;
  logic [W-1:0]      rd_word;
  logic [W-1:0]      rd_data_q, rd_data_d;

  // Requests arriving while the clear runs are never captured, so none survive into READY.
  always_ff @(posedge rclk) begin
    if (reset) begin
      wr_en_d1   <= '0;
      wr_addr_d1 <= '0;
      wr_data_d1 <= '0;
      rd_en_d1   <= 1'b0;
      rd_addr_d1 <= '0;
    end else begin
      wr_en_d1   <= busy ? 2'b00 : frf.wr_en;
      wr_addr_d1 <= frf.wr_addr;
      wr_data_d1 <= frf.wr_data;
      rd_en_d1   <= frf.rd_en & ~busy;
      rd_addr_d1 <= frf.rd_addr;
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q   <= FRF_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == FRF_CLEAR) begin
      if (clr_idx_q == LAST_IDX) begin
        state_d = FRF_READY;
      end else begin
        clr_idx_d = clr_idx_q + 1'b1;
      end
    end
  end

  // The clear sequencer owns the write port until READY; a reset edge writes nothing.
  always_comb begin
    busy       = (state_q == FRF_CLEAR);
    bank_we    = wr_en_d1;
    bank_waddr = wr_addr_d1;
    bank_wdata = wr_data_d1;
    if (busy) begin
      bank_we    = 2'b11;
      bank_waddr = clr_idx_q;
      bank_wdata = '0;
    end
    if (reset) begin
      bank_we = 2'b00;
    end
  end

  for (genvar h = 0; h < 2; h++) begin : g_half
    bw_r_frf_bank #(
      .WIDTH  (HALF_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk     (rclk),
      .we_i    (bank_we[h]),
      .waddr_i (bank_waddr),
      .wdata_i (bank_wdata[h*HALF_W +: HALF_W]),
      .raddr_i (rd_addr_d1),
      .rdata_o (bank_rdata[h*HALF_W +: HALF_W])
    );
  end

  // A same-entry write in flight overrides only the halves it enables.
  always_comb begin
    rd_word = bank_rdata;
    for (int h = 0; h < 2; h++) begin
      if (wr_en_d1[h] && (wr_addr_d1 == rd_addr_d1)) begin
        rd_word[h*HALF_W +: HALF_W] = wr_data_d1[h*HALF_W +: HALF_W];
      end
    end
    rd_data_d = (busy || !rd_en_d1) ? '0 : rd_word;
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign frf.rd_data   = rd_data_q;
  assign frf.init_busy = busy;

endmodule
